// File: rtl/sift_match_pkg.sv
// Shared definitions for the SIFT match pipeline: field widths, matched-entry
// layout {pos, min, min2} and the filter FSM state encoding.
package sift_match_pkg;

  localparam int POS_W   = 19;
  localparam int DIST_W  = 15;
  localparam int ENTRY_W = POS_W + 2 * DIST_W;

  localparam int POS_LSB  = 30;
  localparam int MIN_LSB  = 15;
  localparam int MIN2_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CHK,
    ST_EMIT,
    ST_FIN
  } state_e;

endpackage

// File: rtl/ratio_test.sv
// Combinational Lowe ratio test: pass when min*DEN < min2*NUM, evaluated at a
// width wide enough that neither product can wrap.
module ratio_test
  import sift_match_pkg::*;
#(
  parameter int NUM = 4,
  parameter int DEN = 5
) (
  input  logic [DIST_W-1:0] min_i,
  input  logic [DIST_W-1:0] min2_i,
  output logic              pass_o
);

  localparam int PW = DIST_W + 3;

  logic [PW-1:0] lhs;
  logic [PW-1:0] rhs;

  assign lhs    = PW'(min_i) * PW'(DEN);
  assign rhs    = PW'(min2_i) * PW'(NUM);
  assign pass_o = (lhs < rhs);

endmodule

// File: rtl/match_ratio_filter.sv
// Single pass over the matched-result memory; entries passing the ratio test
// are emitted on a valid/ready stream in address order.
module match_ratio_filter
  import sift_match_pkg::*;
#(
  parameter int MEM_AW    = 6,
  parameter int RATIO_NUM = 4,
  parameter int RATIO_DEN = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [MEM_AW:0]     n_tar_i,
  output logic                mem_re_o,
  output logic [MEM_AW-1:0]   mem_addr_o,
  input  logic [ENTRY_W-1:0]  mem_dout_i,
  output logic                match_valid_o,
  input  logic                match_ready_i,
  output logic [MEM_AW-1:0]   match_tar_idx_o,
  output logic [POS_W-1:0]    match_pos_o,
  output logic [DIST_W-1:0]   match_dist_o,
  output logic [MEM_AW:0]     match_cnt_o,
  output logic                busy_o,
  output logic                done_o,
  output state_e              state_o
);

  localparam logic [MEM_AW-1:0] IDX_ONE = 1;
  localparam logic [MEM_AW:0]   CNT_ONE = 1;

  state_e              state_q, state_d;
  logic [MEM_AW-1:0]   idx_q, idx_d;
  logic [MEM_AW:0]     n_q, n_d;
  logic [MEM_AW:0]     cnt_q, cnt_d;
  logic [MEM_AW-1:0]   tar_q, tar_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [DIST_W-1:0]   dist_q, dist_d;
  logic                pass;
  logic                last;

  ratio_test #(
    .NUM (RATIO_NUM),
    .DEN (RATIO_DEN)
  ) u_ratio (
    .min_i  (mem_dout_i[MIN_LSB +: DIST_W]),
    .min2_i (mem_dout_i[MIN2_LSB +: DIST_W]),
    .pass_o (pass)
  );

  assign last = ({1'b0, idx_q} == (n_q - CNT_ONE));

  // Stream: an entry transfers on any rising edge where match_valid_o and
  // match_ready_i are both high; once raised, valid and data hold until then.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    n_d           = n_q;
    cnt_d         = cnt_q;
    tar_d         = tar_q;
    pos_d         = pos_q;
    dist_d        = dist_q;
    mem_re_o      = 1'b0;
    match_valid_o = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          idx_d   = '0;
          cnt_d   = '0;
          n_d     = n_tar_i;
          state_d = (n_tar_i != '0) ? ST_RD : ST_FIN;
        end
      end
      ST_RD: begin
        busy_o   = 1'b1;
        mem_re_o = 1'b1;
        state_d  = ST_CHK;
      end
      ST_CHK: begin
        busy_o = 1'b1;
        if (pass) begin
          tar_d   = idx_q;
          pos_d   = mem_dout_i[POS_LSB +: POS_W];
          dist_d  = mem_dout_i[MIN_LSB +: DIST_W];
          state_d = ST_EMIT;
        end else if (last) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = ST_RD;
        end
      end
      ST_EMIT: begin
        busy_o        = 1'b1;
        match_valid_o = 1'b1;
        if (match_ready_i) begin
          cnt_d = cnt_q + CNT_ONE;
          if (last) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = ST_RD;
          end
        end
      end
      ST_FIN: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      tar_q   <= '0;
      pos_q   <= '0;
      dist_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      tar_q   <= tar_d;
      pos_q   <= pos_d;
      dist_q  <= dist_d;
    end
  end

  assign mem_addr_o      = idx_q;
  assign match_tar_idx_o = tar_q;
  assign match_pos_o     = pos_q;
  assign match_dist_o    = dist_q;
  assign match_cnt_o     = cnt_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_match_ratio_filter.sv
// Directed and randomized scans of match_ratio_filter against a list-based
// model of the ratio filter and a 1-cycle-latency memory.
`timescale 1ns/1ps
module tb_match_ratio_filter;
  import sift_match_pkg::*;

  localparam int AW     = 6;
  localparam int EW     = AW + POS_W + DIST_W;
  localparam int BUDGET = 5000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               start = 1'b0;
  logic [AW:0]        n_tar = '0;
  logic               mem_re;
  logic [AW-1:0]      mem_addr;
  logic [ENTRY_W-1:0] mem_dout = '0;
  logic               match_valid;
  logic               match_ready = 1'b0;
  logic [AW-1:0]      match_tar_idx;
  logic [POS_W-1:0]   match_pos;
  logic [DIST_W-1:0]  match_dist;
  logic [AW:0]        match_cnt;
  logic               busy;
  logic               done;
  state_e             dbg_state;

  match_ratio_filter #(.MEM_AW(AW), .RATIO_NUM(4), .RATIO_DEN(5)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .n_tar_i         (n_tar),
    .mem_re_o        (mem_re),
    .mem_addr_o      (mem_addr),
    .mem_dout_i      (mem_dout),
    .match_valid_o   (match_valid),
    .match_ready_i   (match_ready),
    .match_tar_idx_o (match_tar_idx),
    .match_pos_o     (match_pos),
    .match_dist_o    (match_dist),
    .match_cnt_o     (match_cnt),
    .busy_o          (busy),
    .done_o          (done),
    .state_o         (dbg_state)
  );

  logic [ENTRY_W-1:0] mem [64];
  always @(posedge clk) if (mem_re) mem_dout <= mem[mem_addr];

  // ---------------- scoreboard ----------------
  int compared   = 0;
  int mismatched = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  int            rd_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] mk(input int pos, input int mn, input int mn2);
    return {POS_W'(pos), DIST_W'(mn), DIST_W'(mn2)};
  endfunction

  // Reference: keep entry i when min/min2 < 4/5, i.e. 5*min < 4*min2.
  function automatic bit ref_pass(input int mn, input int mn2);
    return (mn * 5) < (mn2 * 4);
  endfunction

  task automatic build_exp(input int n);
    int mn, mn2, pos;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      pos = int'(mem[i][POS_LSB +: POS_W]);
      mn  = int'(mem[i][MIN_LSB +: DIST_W]);
      mn2 = int'(mem[i][MIN2_LSB +: DIST_W]);
      if (ref_pass(mn, mn2)) exp_q.push_back({AW'(i), POS_W'(pos), DIST_W'(mn)});
    end
  endtask

  // ---------------- driver ----------------
  // mode 0: ready always high; 1: random ready plus ignored starts while busy;
  // 2: ready held low for the first 10 cycles of the first output.
  task automatic do_scan(input int n, input int mode, output int dcyc);
    int            stall_left;
    bit            hold;
    logic [EW-1:0] prev;
    got_q.delete();
    rd_q.delete();
    dcyc       = -1;
    stall_left = (mode == 2) ? 10 : 0;
    hold       = 1'b0;
    prev       = '0;
    @(negedge clk);
    start = 1'b1;
    n_tar = (AW+1)'(n);
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (mode == 1) match_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && match_valid && stall_left > 0) begin
        match_ready = 1'b0;
        stall_left--;
      end else match_ready = 1'b1;
      if (hold) begin
        check("stall_valid", match_valid, 1);
        check("stall_data", {match_tar_idx, match_pos, match_dist}, prev);
      end
      if (match_valid) check("no_read_in_emit", mem_re, 0);
      if (mem_re) rd_q.push_back(int'(mem_addr));
      if (match_valid && match_ready) got_q.push_back({match_tar_idx, match_pos, match_dist});
      hold = match_valid && !match_ready;
      prev = {match_tar_idx, match_pos, match_dist};
      if (done) begin
        dcyc = cyc;
        break;
      end
      if (mode == 1 && busy && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
        n_tar = (AW+1)'($urandom_range(0, 64));
      end
    end
    start = 1'b0;
    check("done_seen", (dcyc >= 0), 1);
  endtask

  task automatic verify(input int n);
    check("out_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("out_entry", got_q[i], exp_q[i]);
    check("match_cnt", match_cnt, exp_q.size());
    check("read_count", rd_q.size(), n);
    for (int i = 0; i < rd_q.size(); i++) check("read_addr", rd_q[i], i);
    check("busy_at_done", busy, 0);
  endtask

  task automatic fill_random(input int n);
    int mn, mn2, kind;
    for (int i = 0; i < n; i++) begin
      mn2  = $urandom_range(0, 32767);
      kind = $urandom_range(0, 3);
      case (kind)
        0: mn = $urandom_range(0, 32767);
        1: begin
          mn = (mn2 * 4) / 5 + $urandom_range(0, 2) - 1;
          if (mn < 0) mn = 0;
        end
        2: mn = mn2;
        default: mn = $urandom_range(0, 64);
      endcase
      mem[i] = mk($urandom_range(0, (1 << POS_W) - 1), mn, mn2);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d;
    bit found;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_valid", match_valid, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_data", {match_tar_idx, match_pos, match_dist}, 0);
    rst = 1'b0;

    // Basic three-entry scan: only entry 0 passes.
    mem[0] = mk('h00101, 100, 200);
    mem[1] = mk('h00202, 90, 100);
    mem[2] = mk('h00303, 0, 0);
    build_exp(3);
    do_scan(3, 0, d);
    verify(3);
    check("t1_entry", got_q.size() > 0 ? got_q[0] : '0, {6'd0, 19'h00101, 15'd100});
    check("t1_done_cycle", d, 8);
    repeat (3) @(negedge clk);
    check("t1_cnt_hold", match_cnt, 1);

    // Ratio boundaries, including the widest operands.
    mem[0] = mk('h11111, 80, 100);
    mem[1] = mk('h22222, 79, 100);
    mem[2] = mk('h33333, 'h7FFE, 'h7FFF);
    mem[3] = mk('h44444, 'h7FFF, 'h7FFF);
    mem[4] = mk('h55555, 0, 'h7FFF);
    build_exp(5);
    do_scan(5, 0, d);
    verify(5);
    check("t2_npass", got_q.size(), 2);
    check("t2_done_cycle", d, 1 + 2 * 5 + exp_q.size());

    // Empty scan: no memory traffic, done right after the start cycle.
    exp_q.delete();
    do_scan(0, 0, d);
    verify(0);
    check("t3_done_cycle", d, 1);

    // Downstream stall on the first output.
    mem[0] = mk('h0ABCD, 10, 1000);
    mem[1] = mk('h0DCBA, 500, 400);
    build_exp(2);
    do_scan(2, 2, d);
    verify(2);
    check("t4_done_cycle", d, 1 + 2 * 2 + exp_q.size() + 10);

    // Full memory, every entry passing.
    for (int i = 0; i < 64; i++)
      mem[i] = mk($urandom_range(0, (1 << POS_W) - 1), $urandom_range(0, 100), $urandom_range(200, 32767));
    build_exp(64);
    do_scan(64, 0, d);
    verify(64);
    check("t5_last_addr", rd_q.size() > 0 ? rd_q[rd_q.size() - 1] : -1, 63);
    check("t5_done_cycle", d, 1 + 3 * 64);

    // Reset while entry 5 is being offered.
    for (int i = 0; i < 10; i++) mem[i] = mk(i + 7, 1, 100);
    @(negedge clk);
    start = 1'b1;
    n_tar = 7'd10;
    match_ready = 1'b1;
    found = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (match_valid && match_tar_idx == 6'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_reached_entry5", found, 1);
    check("t6_cnt_before_rst", match_cnt, 5);
    rst = 1'b1;
    @(negedge clk);
    check("t6_valid", match_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_cnt", match_cnt, 0);
    check("t6_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    build_exp(3);
    do_scan(3, 0, d);
    verify(3);

    // Randomized scans with random backpressure and ignored restarts.
    for (int t = 0; t < 5; t++) begin
      int n;
      n = $urandom_range(1, 64);
      fill_random(n);
      build_exp(n);
      do_scan(n, 1, d);
      verify(n);
    end
    for (int t = 0; t < 2; t++) begin
      int n;
      n = $urandom_range(1, 64);
      fill_random(n);
      build_exp(n);
      do_scan(n, 0, d);
      verify(n);
      check("rand_done_cycle", d, 1 + 2 * n + exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
